// File: rtl/datapath_seq.sv
`default_nettype none
// ============================================================================
//  Module   : datapath_seq
//  Purpose  : Self-sequencing register-file datapath. A start/busy/done
//             handshake fetches two source registers, runs one ALU operation
//             and writes the result back to a destination register.
//  Revision : 1.0 - initial release
// ============================================================================
module datapath_seq #(
  parameter int WIDTH  = 4,
  parameter int NREGS  = 4,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        opcode,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  input  logic [ADDR_W-1:0] dst,
  input  logic              carry_in,
  input  logic              load,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [WIDTH-1:0]  ld_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic              carry_out,
  output logic              zero
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH_A = 3'd1,
    S_FETCH_B = 3'd2,
    S_EXEC    = 3'd3,
    S_WRITE   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0]  r_rf [NREGS];
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [2:0]        r_op;
  logic [ADDR_W-1:0] r_src_a;
  logic [ADDR_W-1:0] r_src_b;
  logic [ADDR_W-1:0] r_dst;
  logic              r_cin;
  logic [WIDTH-1:0]  r_result;
  logic              r_cout;
  logic              r_zero;
  logic [WIDTH:0]    w_alu;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state and handshake outputs; only IDLE waits for start.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE:    if (start) w_state_next = S_FETCH_A;
      S_FETCH_A: begin busy = 1'b1; w_state_next = S_FETCH_B; end
      S_FETCH_B: begin busy = 1'b1; w_state_next = S_EXEC;    end
      S_EXEC:    begin busy = 1'b1; w_state_next = S_WRITE;   end
      S_WRITE:   begin busy = 1'b1; w_state_next = S_DONE;    end
      S_DONE:    begin done = 1'b1; w_state_next = S_IDLE;    end
      default:   w_state_next = S_IDLE;
    endcase
  end

  // ALU at WIDTH+1 bits; the top bit is carry (ADD) or borrow (SUB).
  always_comb begin
    w_alu = '0;
    case (r_op)
      3'b000:  w_alu = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_cin};
      3'b001:  w_alu = {1'b0, r_a} - {1'b0, r_b} - {{WIDTH{1'b0}}, r_cin};
      3'b010:  w_alu = {1'b0, r_a & r_b};
      3'b011:  w_alu = {1'b0, r_a | r_b};
      3'b100:  w_alu = {1'b0, r_a ^ r_b};
      3'b101:  w_alu = {1'b0, ~(r_a ^ r_b)};
      3'b110:  w_alu = {1'b0, r_a};
      default: w_alu = {1'b0, ~r_a};
    endcase
  end

  // Datapath: command latch and external load in IDLE, operand fetch,
  // flag capture in EXEC and write-back in WRITE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_src_a  <= '0;
      r_src_b  <= '0;
      r_dst    <= '0;
      r_cin    <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= opcode;
            r_src_a <= src_a;
            r_src_b <= src_b;
            r_dst   <= dst;
            r_cin   <= carry_in;
          end
          if (load) r_rf[ld_addr] <= ld_data;
        end
        S_FETCH_A: r_a <= r_rf[r_src_a];
        S_FETCH_B: r_b <= r_rf[r_src_b];
        S_EXEC: begin
          r_result <= w_alu[WIDTH-1:0];
          r_cout   <= w_alu[WIDTH];
          r_zero   <= (w_alu[WIDTH-1:0] == '0);
        end
        S_WRITE: r_rf[r_dst] <= r_result;
        default: ;
      endcase
    end
  end

  assign rd_data   = r_rf[rd_addr];
  assign result    = r_result;
  assign carry_out = r_cout;
  assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_datapath_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_datapath_seq
//  Purpose  : Directed self-checking bench for datapath_seq (4x4 and 8x8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_datapath_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  // 4-bit / 4-entry instance
  logic       start = 0, carry_in = 0, load = 0;
  logic [2:0] opcode = 0;
  logic [1:0] src_a = 0, src_b = 0, dst = 0, ld_addr = 0, rd_addr = 0;
  logic [3:0] ld_data = 0, rd_data, result;
  logic       busy, done, carry_out, zero;

  // 8-bit / 8-entry instance
  logic       start8 = 0, carry_in8 = 0, load8 = 0;
  logic [2:0] opcode8 = 0;
  logic [2:0] src_a8 = 0, src_b8 = 0, dst8 = 0, ld_addr8 = 0, rd_addr8 = 0;
  logic [7:0] ld_data8 = 0, rd_data8, result8;
  logic       busy8, done8, carry_out8, zero8;

  always #5 clk = ~clk;

  datapath_seq #(.WIDTH(4), .NREGS(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .src_a(src_a),
    .src_b(src_b), .dst(dst), .carry_in(carry_in), .load(load),
    .ld_addr(ld_addr), .ld_data(ld_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out), .zero(zero)
  );

  datapath_seq #(.WIDTH(8), .NREGS(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .opcode(opcode8), .src_a(src_a8),
    .src_b(src_b8), .dst(dst8), .carry_in(carry_in8), .load(load8),
    .ld_addr(ld_addr8), .ld_data(ld_data8), .rd_addr(rd_addr8), .rd_data(rd_data8),
    .busy(busy8), .done(done8), .result(result8), .carry_out(carry_out8), .zero(zero8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic ld4(input logic [1:0] a, input logic [3:0] d);
    load = 1; ld_addr = a; ld_data = d;
    @(negedge clk);
    load = 0;
  endtask

  task automatic ld8(input logic [2:0] a, input logic [7:0] d);
    load8 = 1; ld_addr8 = a; ld_data8 = d;
    @(negedge clk);
    load8 = 0;
  endtask

  // One 4-bit operation; optional load on the start edge, optional
  // start/load pulse injected while busy.
  task automatic run_op4(input string tag, input logic [2:0] op, input logic [1:0] sa,
                         input logic [1:0] sb, input logic [1:0] ds, input logic ci,
                         input logic [3:0] er, input logic ec,
                         input logic do_ld, input logic [1:0] la, input logic [3:0] ldv,
                         input logic glitch);
    opcode = op; src_a = sa; src_b = sb; dst = ds; carry_in = ci; rd_addr = ds;
    start = 1; load = do_ld; ld_addr = la; ld_data = ldv;
    @(negedge clk);
    start = 0; load = 0;
    check({tag, "_busy0"}, 32'(busy), 32'd1);
    check({tag, "_done0"}, 32'(done), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      if (glitch && i == 1) begin
        start = 1; opcode = 3'b001; load = 1; ld_addr = 2'd3; ld_data = 4'd9;
      end
      @(negedge clk);
      start = 0; load = 0;
      check({tag, "_busy"}, 32'(busy), 32'(i < 4));
      check({tag, "_done"}, 32'(done), 32'(i == 4));
      if (i == 3) begin
        check({tag, "_res"},  32'(result),    32'(er));
        check({tag, "_cout"}, 32'(carry_out), 32'(ec));
        check({tag, "_zero"}, 32'(zero),      32'(er == 4'd0));
      end
      if (i == 4) check({tag, "_wb"}, 32'(rd_data), 32'(er));
    end
    @(negedge clk);
    check({tag, "_done_fall"}, 32'(done), 32'd0);
  endtask

  task automatic run_op8(input string tag, input logic [2:0] sa, input logic [2:0] sb,
                         input logic [2:0] ds, input logic [7:0] er, input logic ec);
    opcode8 = 3'b000; src_a8 = sa; src_b8 = sb; dst8 = ds; carry_in8 = 0; rd_addr8 = ds;
    start8 = 1;
    @(negedge clk);
    start8 = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 3) begin
        check({tag, "_res"},  32'(result8),    32'(er));
        check({tag, "_cout"}, 32'(carry_out8), 32'(ec));
        check({tag, "_zero"}, 32'(zero8),      32'(er == 8'd0));
      end
      if (i == 4) begin
        check({tag, "_done"}, 32'(done8),    32'd1);
        check({tag, "_wb"},   32'(rd_data8), 32'(er));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    // Reset state
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_res",  32'(result), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    rst = 0;
    @(negedge clk);

    // Arithmetic
    ld4(0, 7); ld4(1, 1);
    run_op4("add_7_1",  3'b000, 0, 1, 2, 0, 4'd8,  0, 0, 0, 0, 0);
    ld4(0, 15);
    run_op4("add_15_1", 3'b000, 0, 1, 2, 0, 4'd0,  1, 0, 0, 0, 0);
    ld4(0, 7);
    run_op4("add_7_7c", 3'b000, 0, 0, 2, 1, 4'd15, 0, 0, 0, 0, 0);
    ld4(0, 5); ld4(1, 7);
    run_op4("sub_5_7",  3'b001, 0, 1, 2, 0, 4'd14, 1, 0, 0, 0, 0);
    // Logic ops force carry to 0 even with carry_in set
    run_op4("and",      3'b010, 0, 1, 2, 1, 4'd5,  0, 0, 0, 0, 0);
    run_op4("or",       3'b011, 0, 1, 2, 0, 4'd7,  0, 0, 0, 0, 0);
    run_op4("xor",      3'b100, 0, 1, 2, 0, 4'd2,  0, 0, 0, 0, 0);
    run_op4("xnor",     3'b101, 0, 1, 2, 0, 4'd13, 0, 0, 0, 0, 0);
    run_op4("pass",     3'b110, 0, 1, 2, 0, 4'd5,  0, 0, 0, 0, 0);
    run_op4("not",      3'b111, 0, 1, 2, 0, 4'd10, 0, 0, 0, 0, 0);
    run_op4("sub_7_5c", 3'b001, 1, 0, 2, 1, 4'd1,  0, 0, 0, 0, 0);

    // start/load while busy are ignored
    ld4(3, 6);
    run_op4("busy_ign", 3'b000, 0, 1, 2, 0, 4'd12, 0, 0, 0, 0, 1);
    seen = 0;
    rd_addr = 3;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy) seen = 1;
    end
    check("no_second_op", 32'(seen), 32'd0);
    check("r3_kept", 32'(rd_data), 32'd6);

    // load and start on the same edge: fetch sees the loaded value
    run_op4("ld_start", 3'b000, 0, 1, 2, 0, 4'd10, 0, 1, 0, 3, 0);

    // Reset during EXEC
    opcode = 3'b000; src_a = 0; src_b = 1; dst = 3; carry_in = 0; start = 1;
    @(negedge clk); start = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_res",  32'(result), 32'd0);
    check("mid_rst_cout", 32'(carry_out), 32'd0);
    check("mid_rst_zero", 32'(zero), 32'd0);
    for (int r = 0; r < 4; r++) begin
      rd_addr = 2'(r);
      #1;
      check("mid_rst_rf", 32'(rd_data), 32'd0);
    end
    @(negedge clk);
    rst = 0;
    seen = 0;
    rd_addr = 3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy || done) seen = 1;
    end
    check("abort_idle", 32'(seen), 32'd0);
    check("abort_no_wb", 32'(rd_data), 32'd0);
    ld4(0, 2); ld4(1, 3);
    run_op4("post_rst", 3'b000, 0, 1, 3, 0, 4'd5, 0, 0, 0, 0, 0);

    // 8-bit, 8-entry instance
    ld8(7, 8'd200); ld8(6, 8'd100);
    run_op8("w8_add", 7, 6, 7, 8'd44, 1);
    run_op8("w8_self", 7, 7, 7, 8'd88, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
